// File: rtl/dlx_regfile.sv
// DLX decode-stage integer register file: one write port from writeback, two
// read ports feeding registered A/B operands, with same-cycle write bypass.

module dlx_regfile_rdport #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic [4:0]                   rs,
    input  logic                         wb_write_en,
    input  logic [4:0]                   wb_add_in,
    input  logic [WIDTH-1:0]             wb_data_in,
    input  logic [NREGS-1:0][WIDTH-1:0]  regs,
    output logic [WIDTH-1:0]             rd_val
);
    // R0 wins over the bypass so a discarded write to R0 never leaks through
    always_comb begin
        rd_val = regs[rs];
        if (rs == 5'd0)
            rd_val = '0;
        else if (wb_write_en && (wb_add_in == rs))
            rd_val = wb_data_in;
    end
endmodule

module dlx_regfile #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic              clock2,
    input  logic              reset2,
    input  logic [31:0]       inst_in2,
    input  logic [4:0]        wb_add_in,
    input  logic [WIDTH-1:0]  wb_data_in,
    input  logic              wb_write_en,
    output logic [31:0]       inst_out2,
    output logic [WIDTH-1:0]  reg_a_out,
    output logic [WIDTH-1:0]  reg_b_out
);
    localparam int NRD = 2;

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [NRD-1:0][4:0]         rs;
    logic [NRD-1:0][WIDTH-1:0]   rd_val;

    assign rs[0] = inst_in2[25:21];
    assign rs[1] = inst_in2[20:16];

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        dlx_regfile_rdport #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rd (
            .rs          (rs[p]),
            .wb_write_en (wb_write_en),
            .wb_add_in   (wb_add_in),
            .wb_data_in  (wb_data_in),
            .regs        (regs),
            .rd_val      (rd_val[p])
        );
    end

    // Entry 0 is cleared by reset and never written, so it stays zero
    always_ff @(posedge clock2 or negedge reset2) begin
        if (!reset2) begin
            regs <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++)
                if (wb_write_en && (wb_add_in == 5'(i)))
                    regs[i] <= wb_data_in;
        end
    end

    always_ff @(posedge clock2 or negedge reset2) begin
        if (!reset2) begin
            inst_out2 <= '0;
            reg_a_out <= '0;
            reg_b_out <= '0;
        end else begin
            inst_out2 <= inst_in2;
            reg_a_out <= rd_val[0];
            reg_b_out <= rd_val[1];
        end
    end

    wb_en_known: assert property (@(posedge clock2) disable iff (!reset2) !$isunknown(wb_write_en))
        else $error("wb_write_en is X/Z");
endmodule
